// File: rtl/fpu_issue.sv
// Issue front-end between the FP execute stage and four FPU units (fadd, fmul, fdiv, fsqrt).
// Optional protocol checking of unit handshakes is enabled with `define FPU_ISSUE_PROTO_CHECK_EN.
module fpu_issue #(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [31:0]        in_rs1,
  input  logic [31:0]        in_rs2,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_rd,
  output logic [TAG_W-1:0]   out_tag,
  output logic [3:0]         u_order,
  input  logic [3:0]         u_accepted,
  input  logic [3:0]         u_done,
  output logic [127:0]       u_rs1,
  output logic [127:0]       u_rs2,
  input  logic [127:0]       u_rd,
  output logic               err,
  output logic [7:0]         dbg_state
);

  // Core side: valid/ready; a transfer happens on a rising edge where valid & ready are both high.
  // Unit side: order is held until accepted; done is a single-cycle pulse carrying u_rd.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ORDER = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e             state_q [4];
  state_e             state_d [4];
  logic [31:0]        rs1_q   [4];
  logic [31:0]        rs1_d   [4];
  logic [31:0]        rs2_q   [4];
  logic [31:0]        rs2_d   [4];
  logic [31:0]        rd_q    [4];
  logic [31:0]        rd_d    [4];
  logic [TAG_W-1:0]   tag_q   [4];
  logic [TAG_W-1:0]   tag_d   [4];
  logic [3:0]         u_order_q, u_order_d;
  logic [1:0]         ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_rd_q, out_rd_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic               issue;
  logic               out_load;
  logic               grant;
  logic               gnt_found;
  logic [1:0]         gnt_idx;
  logic [1:0]         rr_idx;

  // Readiness depends only on the selected unit's registered state, never on u_* inputs.
  assign in_ready = (state_q[in_op] == S_IDLE);
  assign issue    = in_valid & in_ready;
  assign out_load = ~out_valid_q | out_ready;
  assign grant    = out_load & gnt_found;

  // Round-robin search starting at the pointer, wrapping 3 -> 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    rr_idx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!gnt_found && state_q[rr_idx] == S_HOLD) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      rs1_d[i]   = rs1_q[i];
      rs2_d[i]   = rs2_q[i];
      rd_d[i]    = rd_q[i];
      tag_d[i]   = tag_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (issue && in_op == 2'(i)) begin
            state_d[i] = S_ORDER;
            rs1_d[i]   = in_rs1;
            rs2_d[i]   = in_rs2;
            tag_d[i]   = in_tag;
          end
        end
        S_ORDER: begin
          if (u_accepted[i]) begin
            if (u_done[i]) begin
              state_d[i] = S_HOLD;
              rd_d[i]    = u_rd[32*i +: 32];
            end else begin
              state_d[i] = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (u_done[i]) begin
            state_d[i] = S_HOLD;
            rd_d[i]    = u_rd[32*i +: 32];
          end
        end
        S_HOLD: begin
          // Released only on the edge; re-issue is possible from the following cycle.
          if (grant && gnt_idx == 2'(i)) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      u_order_d[i] = (state_d[i] == S_ORDER);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_tag_d   = out_tag_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_rd_d    = rd_q[gnt_idx];
      out_tag_d   = tag_q[gnt_idx];
      ptr_d       = gnt_idx + 2'd1;
    end else if (out_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= S_IDLE;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
        rd_q[i]    <= '0;
        tag_q[i]   <= '0;
      end
      u_order_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        rs1_q[i]   <= rs1_d[i];
        rs2_q[i]   <= rs2_d[i];
        rd_q[i]    <= rd_d[i];
        tag_q[i]   <= tag_d[i];
      end
      u_order_q   <= u_order_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
    end
  end

`ifdef FPU_ISSUE_PROTO_CHECK_EN
  logic err_q, err_d, proto_err;

  // A handshake pulse the unit FSM cannot use is flagged; the FSM itself ignores it.
  always_comb begin
    proto_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (state_q[i])
        S_IDLE, S_HOLD: if (u_done[i] | u_accepted[i]) proto_err = 1'b1;
        S_ORDER:        if (u_done[i] & ~u_accepted[i]) proto_err = 1'b1;
        S_WAIT:         if (u_accepted[i]) proto_err = 1'b1;
        default:        proto_err = 1'b0;
      endcase
    end
    err_d = err_q | proto_err;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_tag   = out_tag_q;
  assign u_order   = u_order_q;
  assign u_rs1     = {rs1_q[3], rs1_q[2], rs1_q[1], rs1_q[0]};
  assign u_rs2     = {rs2_q[3], rs2_q[2], rs2_q[1], rs2_q[0]};
  assign dbg_state = {state_q[3], state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: table-driven minimum-latency vectors plus
// hand-written multi-cycle sequences, with an in-order result scoreboard.
module tb_fpu_issue;
  localparam int TAG_W = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_op = '0;
  logic [31:0]        in_rs1 = '0;
  logic [31:0]        in_rs2 = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_rd;
  logic [TAG_W-1:0]   out_tag;
  logic [3:0]         u_order;
  logic [3:0]         u_accepted = '0;
  logic [3:0]         u_done = '0;
  logic [127:0]       u_rs1, u_rs2;
  logic [127:0]       u_rd = '0;
  logic               err;
  logic [7:0]         dbg_state;

  int checks = 0;
  int failures = 0;
  logic [TAG_W+31:0] exp_q[$];

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      rd;
  } vec_t;
  vec_t vecs[6];

  fpu_issue #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd(out_rd), .out_tag(out_tag), .u_order(u_order),
    .u_accepted(u_accepted), .u_done(u_done), .u_rs1(u_rs1), .u_rs2(u_rs2),
    .u_rd(u_rd), .err(err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: results are popped in order as the core consumes them.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {27'd0, out_tag, out_rd}, 64'hDEAD);
      end else begin
        chk("sb_result", {27'd0, out_tag, out_rd}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resp();
    u_accepted = '0;
    u_done = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
    in_op = op; in_rs1 = a; in_rs2 = b; in_tag = t; in_valid = 1'b1;
    #1;
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] op, input logic acc, input logic done,
                         input logic [31:0] rd, input logic [TAG_W-1:0] t);
    u_accepted[op] = acc;
    u_done[op] = done;
    u_rd[32*op +: 32] = rd;
    if (done) exp_q.push_back({t, rd});
  endtask

  initial begin
    vecs[0] = '{op: 2'd0, rs1: 32'h3F800000, rs2: 32'h3F800000, tag: 5'd1,  rd: 32'h40000000};
    vecs[1] = '{op: 2'd1, rs1: 32'h40000000, rs2: 32'h40400000, tag: 5'd2,  rd: 32'h40C00000};
    vecs[2] = '{op: 2'd2, rs1: 32'h41000000, rs2: 32'h40000000, tag: 5'd31, rd: 32'h40800000};
    vecs[3] = '{op: 2'd3, rs1: 32'h41800000, rs2: 32'hFFFFFFFF, tag: 5'd0,  rd: 32'h40800000};
    vecs[4] = '{op: 2'd0, rs1: 32'hBF800000, rs2: 32'h3F800000, tag: 5'd17, rd: 32'h00000000};
    vecs[5] = '{op: 2'd3, rs1: 32'h00000000, rs2: 32'h12345678, tag: 5'd9,  rd: 32'h00000000};

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_rd", {32'd0, out_rd}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_u_order", {60'd0, u_order}, 64'd0);
    chk("rst_u_rs1", u_rs1[63:0] | u_rs1[127:64], 64'd0);
    chk("rst_u_rs2", u_rs2[63:0] | u_rs2[127:64], 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    for (int op = 0; op < 4; op++) begin
      in_op = 2'(op);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    end

    // Table: accepted and done in the first order cycle -> 3-cycle latency
    foreach (vecs[v]) begin
      issue(vecs[v].op, vecs[v].rs1, vecs[v].rs2, vecs[v].tag);
      chk("vec_order", {60'd0, u_order}, {60'd0, 4'b0001 << vecs[v].op});
      chk("vec_rs1", {32'd0, u_rs1[32*vecs[v].op +: 32]}, {32'd0, vecs[v].rs1});
      chk("vec_rs2", {32'd0, u_rs2[32*vecs[v].op +: 32]}, {32'd0, vecs[v].rs2});
      in_op = vecs[v].op;
      #1;
      chk("vec_busy", {63'd0, in_ready}, 64'd0);
      respond(vecs[v].op, 1'b1, 1'b1, vecs[v].rd, vecs[v].tag);
      tick();
      clear_resp();
      chk("vec_lat2_valid", {63'd0, out_valid}, 64'd0);
      tick();
      chk("vec_lat3_valid", {63'd0, out_valid}, 64'd1);
      chk("vec_tag", {59'd0, out_tag}, {59'd0, vecs[v].tag});
      tick();
      chk("vec_drained", {63'd0, out_valid}, 64'd0);
    end

    // fadd: accepted at T+1, done at T+4, out_valid at T+6
    issue(2'd0, 32'h3F800000, 32'h40000000, 5'd3);
    for (int c = 1; c <= 6; c++) begin
      chk("fadd_order", {60'd0, u_order}, (c == 1) ? 64'd1 : 64'd0);
      clear_resp();
      if (c == 1) respond(2'd0, 1'b1, 1'b0, 32'd0, 5'd3);
      if (c == 4) respond(2'd0, 1'b0, 1'b1, 32'h40400000, 5'd3);
      if (c == 5) chk("fadd_valid_t5", {63'd0, out_valid}, 64'd0);
      if (c == 6) begin
        chk("fadd_valid_t6", {63'd0, out_valid}, 64'd1);
        chk("fadd_rd", {32'd0, out_rd}, 64'h40400000);
        chk("fadd_tag", {59'd0, out_tag}, 64'd3);
      end
      tick();
    end

    // Accepted withheld for 5 cycles on fmul
    issue(2'd1, 32'h11111111, 32'h22222222, 5'd7);
    for (int k = 0; k < 5; k++) begin
      chk("hold_order", {63'd0, u_order[1]}, 64'd1);
      chk("hold_rs1", {32'd0, u_rs1[63:32]}, 64'h11111111);
      chk("hold_rs2", {32'd0, u_rs2[63:32]}, 64'h22222222);
      for (int op = 0; op < 4; op++) begin
        in_op = 2'(op);
        #1;
        chk("hold_in_ready", {63'd0, in_ready}, (op == 1) ? 64'd0 : 64'd1);
      end
      tick();
    end
    respond(2'd1, 1'b1, 1'b1, 32'h33333333, 5'd7);
    tick(); clear_resp();
    tick();
    chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    tick();

    // fdiv then fsqrt; fsqrt completes first
    issue(2'd2, 32'h41200000, 32'h40000000, 5'd1);
    respond(2'd2, 1'b1, 1'b0, 32'd0, 5'd1);
    issue(2'd3, 32'h41100000, 32'h0, 5'd2);
    clear_resp(); respond(2'd3, 1'b1, 1'b0, 32'd0, 5'd2);
    tick(); clear_resp(); respond(2'd3, 1'b0, 1'b1, 32'h40400000, 5'd2);
    tick(); clear_resp(); respond(2'd2, 1'b0, 1'b1, 32'h40A00000, 5'd1);
    tick(); clear_resp();
    chk("ooo_first_tag", {59'd0, out_tag}, 64'd2);
    tick();
    chk("ooo_second_tag", {59'd0, out_tag}, 64'd1);
    tick();

    // Pointer is now 3; one fmul grant moves it to 2
    issue(2'd1, 32'h1, 32'h2, 5'd20);
    respond(2'd1, 1'b1, 1'b1, 32'h3, 5'd20);
    tick(); clear_resp(); tick(); tick();

    // Four simultaneous dones with pointer 2 -> tags in unit order 2,3,0,1
    issue(2'd0, 32'hA0, 32'hB0, 5'd10);
    respond(2'd0, 1'b1, 1'b0, 32'd0, 5'd10);
    issue(2'd1, 32'hA1, 32'hB1, 5'd11);
    clear_resp(); respond(2'd1, 1'b1, 1'b0, 32'd0, 5'd11);
    issue(2'd2, 32'hA2, 32'hB2, 5'd12);
    clear_resp(); respond(2'd2, 1'b1, 1'b0, 32'd0, 5'd12);
    issue(2'd3, 32'hA3, 32'hB3, 5'd13);
    clear_resp(); respond(2'd3, 1'b1, 1'b0, 32'd0, 5'd13);
    for (int op = 0; op < 4; op++) begin
      in_op = 2'(op);
      #1;
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    end
    tick(); clear_resp();
    u_done = 4'hF;
    u_rd = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    exp_q.push_back({5'd12, 32'hC2});
    exp_q.push_back({5'd13, 32'hC3});
    exp_q.push_back({5'd10, 32'hC0});
    exp_q.push_back({5'd11, 32'hC1});
    tick(); clear_resp();
    chk("all4_hold_state", {56'd0, dbg_state}, 64'hFF);
    chk("all4_not_yet", {63'd0, out_valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("all4_valid", {63'd0, out_valid}, 64'd1);
      chk("all4_tag", {59'd0, out_tag}, (k < 2) ? 64'(12 + k) : 64'(8 + k));
    end
    tick();
    chk("all4_drained", {63'd0, out_valid}, 64'd0);

    // Back-pressure: one result stalled, second done held in HOLD
    issue(2'd0, 32'h5, 32'h6, 5'd4);
    respond(2'd0, 1'b1, 1'b1, 32'hAAAA0001, 5'd4);
    issue(2'd1, 32'h7, 32'h8, 5'd5);
    clear_resp(); respond(2'd1, 1'b1, 1'b0, 32'd0, 5'd5);
    tick(); clear_resp();
    out_ready = 1'b0;
    respond(2'd1, 1'b0, 1'b1, 32'hBBBB0002, 5'd5);
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_rd", {32'd0, out_rd}, 64'hAAAA0001);
      chk("bp_tag", {59'd0, out_tag}, 64'd4);
      if (k >= 2) chk("bp_u1_hold", {62'd0, dbg_state[3:2]}, 64'd3);
      tick(); clear_resp();
    end
    out_ready = 1'b1;
    chk("bp_release_rd", {32'd0, out_rd}, 64'hAAAA0001);
    tick();
    chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_second_tag", {59'd0, out_tag}, 64'd5);
    chk("bp_second_rd", {32'd0, out_rd}, 64'hBBBB0002);
    tick();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset mid-operation
    issue(2'd2, 32'h99, 32'h98, 5'd6);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_op = 2'd2;
    #1;
    chk("midrst_order", {60'd0, u_order}, 64'd0);
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_slot", {32'd0, u_rs1[95:64]}, 64'd0);
    tick();

    // Stray done on an idle unit
    u_done[1] = 1'b1;
    u_rd[63:32] = 32'hEEEEEEEE;
    tick(); clear_resp();
`ifdef FPU_ISSUE_PROTO_CHECK_EN
    chk("stray_err", {63'd0, err}, 64'd1);
`else
    chk("stray_err", {63'd0, err}, 64'd0);
`endif
    chk("stray_no_out", {63'd0, out_valid}, 64'd0);
    chk("stray_state", {56'd0, dbg_state}, 64'd0);
    tick();
    chk("stray_no_out2", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stray_err_cleared", {63'd0, err}, 64'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Issue front-end that sits between the core's FP execute stage and the four FPU units (fadd, fmul, fdiv, fsqrt). It accepts one operation at a time from the core and drives the selected unit as initiator of the order/accepted/done handshake. It captures each result in the unit's single done cycle and returns results to the core with their tag through a one-entry valid/ready output register. Up to one operation is outstanding per unit, so up to four are in flight at once; results return in completion order, not issue order.

## Interface
- TAG_W, 5: width of the core's result tag.
- clk  in  1  clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  core presents an operation.
- in_ready  out  1  combinational: high when unit in_op is IDLE.
- in_op  in  2  selects the unit: 0 fadd, 1 fmul, 2 fdiv, 3 fsqrt.
- in_rs1, in_rs2  in  32 each  operands; in_rs2 is ignored for fsqrt.
- in_tag  in  TAG_W  returned with the result.
- out_valid  out  1  result available.
- out_ready  in  1  core consumes the result.
- out_rd  out  32  result.
- out_tag  out  TAG_W  tag of the result.
- u_order  out  4  per-unit order, registered.
- u_accepted  in  4  per-unit accepted.
- u_done  in  4  per-unit done pulse.
- u_rs1, u_rs2  out  4x32 each  per-unit operands, unit i at bits [32i+31:32i].
- u_rd  in  4x32  per-unit result; valid only in the u_done cycle.
- err  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Each unit i has its own FSM with states IDLE, ORDER, WAIT and HOLD.
  - IDLE -> ORDER on issue (in_valid & in_ready & in_op==i). The same edge latches in_rs1, in_rs2 and in_tag into unit i's slot.
  - ORDER: u_order[i]=1.
    - accepted & ~done -> WAIT.
    - accepted & done -> HOLD, and u_rd[i] is captured.
    - Otherwise stay in ORDER with order held.
  - WAIT: u_order[i]=0. On done, capture u_rd[i] and go to HOLD.
  - HOLD: the result waits for the output register. On grant -> IDLE.
- u_rs1/u_rs2 of unit i are driven from the slot. They stay stable from ORDER entry until the unit leaves WAIT.
- Output register:
  - It loads when empty, or when the current entry is consumed (out_valid & out_ready) in the same cycle.
  - It holds out_rd/out_tag unchanged while out_valid & ~out_ready.
- Arbitration is round-robin over units in HOLD.
  - The pointer is 0 after reset.
  - Grant goes to the first HOLD unit at index >= pointer, wrapping at 3 -> 0.
  - After a grant the pointer becomes granted+1 mod 4.
  - A grant only happens in a cycle where the register loads.
- A unit leaving HOLD on grant can accept a new issue on the next cycle, not the same cycle.
- Reset values:
  - All FSMs IDLE; u_order=0; out_valid=0; out_rd=0; out_tag=0; err=0; pointer=0.
  - Slots are cleared to 0; u_rs1/u_rs2 are therefore 0.
- Reset mid-operation discards all in-flight work. The units share rst, so no late done is expected.

## Timing
- Issue accepted at edge of cycle T:
  - ORDER, u_order high from T+1.
  - Accepted in cycle A>=T+1: u_order low from A+1.
  - Done in cycle D: HOLD from D+1; out_valid from D+2 at the earliest (with grant in D+1).
- Minimum in->out latency is 3 cycles: accepted and done both in T+1.
- in_ready has a combinational path from in_op. There is no path from u_* inputs to in_ready.
- Simultaneous done from several units: all are captured the same cycle. They drain one per cycle, in round-robin order, while out_ready=1.
- Full condition: when all four units are busy, in_ready=0 for every in_op. The output register back-pressures only via HOLD; done is never dropped.

## Configuration
- FPU_ISSUE_PROTO_CHECK_EN defined: err is set (sticky until rst) when any of the following occurs:
  - u_done[i] arrives while unit i is IDLE, ORDER-without-accepted, or HOLD; or
  - u_accepted[i] arrives while unit i is not in ORDER.

  The offending done is ignored and state is unchanged.
- Not defined: err is tied 0. Stray done or accepted is ignored silently.

## Test plan
- fadd issue: rs1=0x3F800000, rs2=0x40000000, tag=3. Unit accepts at T+1 and asserts done with rd=0x40400000 at T+4. Required: out_valid at T+6 with out_rd=0x40400000, out_tag=3; u_order high only in cycle T+1.
- Unit holds accepted low for 5 cycles. Required: u_order stays high and operands stable throughout; in_ready=0 for that in_op and 1 for the other ops.
- Issue fdiv (tag 1), then fsqrt (tag 2) one cycle later. fsqrt completes first. Required: tag 2 is returned before tag 1.
- All four units assert done in the same cycle with out_ready=1, pointer=2. Required: outputs on four consecutive cycles, tags in unit order 2, 3, 0, 1.
- out_ready=0 for 4 cycles with one result pending and a second done arriving. Required: out_rd/out_tag stable; second result is held in HOLD and delivered on the cycle after the first is consumed.
- With FPU_ISSUE_PROTO_CHECK_EN: u_done[1] pulsed while unit 1 is IDLE -> err=1 next cycle, out_valid stays 0; rst -> err=0.
